seq_signed_multiplier: RTL and testbench
========================================

Name: seq_signed_multiplier

Overview:
Sequential shift-add signed multiplier core. It consumes the one-cycle start pulse produced by pushbutton_detector (its z output).
- Operands are captured from the switch inputs on that pulse.
- Multiplication is done on magnitudes over WIDTH cycles.
- The signed product is held for the display path, which sits downstream.
- Runs in the same divided-clock domain as the detector output.

Parameters:
WIDTH, 8, operand width in bits. Product width is 2*WIDTH.

Ports:
clk  input  1  block clock (same domain as the start pulse source)
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle start pulse from pushbutton_detector.z
a  input  WIDTH  multiplicand, two's complement
b  input  WIDTH  multiplier, two's complement
product  output  2*WIDTH  signed product, two's complement, held until next completion
negative  output  1  1 when held product < 0
busy  output  1  1 while a multiplication is in progress (LOAD..FINISH)
done  output  1  one-cycle pulse when product/negative update

Behaviour:
- Reset (async, rst=1): state=IDLE; product=0, negative=0, busy=0, done=0; internal accumulator/counter cleared. Applies immediately even mid-operation; the in-flight result is discarded.
- States: IDLE, RUN, FINISH.
- IDLE:
  - On a clock edge with start=1: capture mag_a=|a| and mag_b=|b| as WIDTH-bit unsigned; capture sgn=a[MSB]^b[MSB]; clear acc (2*WIDTH bits) and cnt; go to RUN.
  - busy=1 from the following cycle.
  - start=0: stay in IDLE; outputs hold.
- Magnitude rule: |-2^(WIDTH-1)| = 2^(WIDTH-1), representable in WIDTH unsigned bits (e.g. -128 -> 8'h80). No saturation needed.
- RUN, one partial product per cycle, exactly WIDTH cycles:
  - If mag_b[0]=1: acc += mag_a << cnt (zero-extended to 2*WIDTH).
  - Then mag_b >>= 1 and cnt += 1.
  - After the cycle with cnt=WIDTH-1, go to FINISH.
- FINISH, one cycle, on its edge:
  - If sgn=1 and acc!=0: product <= two's complement negation of acc and negative <= 1.
  - Otherwise: product <= acc and negative <= 0. A zero result is never flagged negative.
  - done=1 for exactly one cycle; busy=0 from the next cycle; return to IDLE.
- Latency: start captured at edge E0; product, negative and done appear after edge E0+WIDTH+1 (edge E9 for WIDTH=8). done is high for one cycle. busy is high for WIDTH+1 cycles.
- start while busy (RUN/FINISH): ignored, not queued.
- start in the same cycle done is high: the state is IDLE in that cycle, so it is accepted normally. The new operation begins; product holds its old value until its own FINISH.
- Operand inputs a/b are sampled only at start acceptance; later changes have no effect on the running operation.
- Range: the result always fits in 2*WIDTH signed bits. The extreme is (-128)*(-128)=+16384 = 16'h4000, so no overflow handling is required.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package (mult_pkg): state encoding constants (IDLE, RUN, FINISH) and the default WIDTH constant.
- Sub-module twos_abs (WIDTH-bit two's complement to WIDTH-bit unsigned magnitude, combinational). Instantiated twice, for a and b.
- The datapath and FSM stay in seq_signed_multiplier.

Test Plan:
1. Reset then idle: rst pulse, no start -> product=0, negative=0, busy=0, done=0 held for 20 cycles. Assert rst mid-RUN -> immediate return to all-zero outputs, and no done pulse follows.
2. Basic signs: a=5, b=-3, start pulse -> done exactly 9 edges after capture; product=16'hFFF1 (-15), negative=1. Also a=-7, b=-6 -> product=16'h002A (+42), negative=0.
3. Extremes: a=-128, b=-128 -> product=16'h4000. a=-128, b=127 -> product=16'hC080 (-16256). a=127, b=127 -> product=16'h3F01.
4. Zero sign rule: a=-9, b=0 -> product=0, negative=0. a=0, b=-1 -> product=0, negative=0.
5. Start while busy: start at E0 with a=3, b=4; second start at E4 with a=9, b=9; change a/b mid-run -> single done with product=12; no second done.
6. Back-to-back: start again in the cycle done is high (a=-2, b=2) -> accepted. product stays 12 until the second done, 9 edges later, then becomes 16'hFFFC. busy stays high through the second operation.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential signed multiplier: controller state
// encoding and the default operand width.
package mult_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/twos_abs.sv
// Combinational two's-complement magnitude. The most negative input maps to
// 2^(WIDTH-1), which still fits because the result is read as unsigned.
module twos_abs #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] magnitude
);

    assign magnitude = value[WIDTH-1] ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/seq_signed_multiplier.sv
// Shift-add signed multiplier: magnitudes are multiplied one partial product
// per cycle, and the sign is applied once in FINISH.
module seq_signed_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   product,
    output logic                 negative,
    output logic                 busy,
    output logic                 done
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   mag_a_reg, mag_a_next;
    logic [WIDTH-1:0]   mag_b_reg, mag_b_next;
    logic               sgn_reg, sgn_next;
    logic [PW-1:0]      acc_reg, acc_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [PW-1:0]      product_reg, product_next;
    logic               negative_reg, negative_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;

    logic [WIDTH-1:0]   operand   [2];
    logic [WIDTH-1:0]   magnitude [2];

    assign operand[0] = a;
    assign operand[1] = b;

    for (genvar gi = 0; gi < 2; gi++) begin : g_abs
        twos_abs #(
            .WIDTH (WIDTH)
        ) u_abs (
            .value     (operand[gi]),
            .magnitude (magnitude[gi])
        );
    end

    always_comb begin
        state_next    = state_reg;
        mag_a_next    = mag_a_reg;
        mag_b_next    = mag_b_reg;
        sgn_next      = sgn_reg;
        acc_next      = acc_reg;
        cnt_next      = cnt_reg;
        product_next  = product_reg;
        negative_next = negative_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    mag_a_next = magnitude[0];
                    mag_b_next = magnitude[1];
                    sgn_next   = a[WIDTH-1] ^ b[WIDTH-1];
                    acc_next   = '0;
                    cnt_next   = '0;
                    busy_next  = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (mag_b_reg[0]) begin
                    acc_next = acc_reg + (PW'(mag_a_reg) << cnt_reg);
                end
                mag_b_next = mag_b_reg >> 1;
                cnt_next   = cnt_reg + CNT_W'(1);
                if (cnt_reg == CNT_W'(WIDTH - 1)) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                // A zero magnitude stays non-negative regardless of operand signs.
                if (sgn_reg && (acc_reg != '0)) begin
                    product_next  = ~acc_reg + PW'(1);
                    negative_next = 1'b1;
                end else begin
                    product_next  = acc_reg;
                    negative_next = 1'b0;
                end
                done_next  = 1'b1;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: begin
                busy_next  = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            mag_a_reg    <= '0;
            mag_b_reg    <= '0;
            sgn_reg      <= 1'b0;
            acc_reg      <= '0;
            cnt_reg      <= '0;
            product_reg  <= '0;
            negative_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            mag_a_reg    <= mag_a_next;
            mag_b_reg    <= mag_b_next;
            sgn_reg      <= sgn_next;
            acc_reg      <= acc_next;
            cnt_reg      <= cnt_next;
            product_reg  <= product_next;
            negative_reg <= negative_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
        end
    end

    assign product  = product_reg;
    assign negative = negative_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;

endmodule

// File: tb/tb_seq_signed_multiplier.sv
// Self-checking bench for seq_signed_multiplier (WIDTH=8): directed corner
// cases plus random operands against an integer-arithmetic reference.
module tb_seq_signed_multiplier;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic [2*W-1:0] product;
    logic           negative;
    logic           busy;
    logic           done;

    int n_checks = 0;
    int n_fail   = 0;

    seq_signed_multiplier #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .product  (product),
        .negative (negative),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain signed integer multiply.
    function automatic logic [2*W-1:0] ref_product(input logic signed [W-1:0] x,
                                                   input logic signed [W-1:0] y);
        int p;
        logic [31:0] pv;
        p  = int'(x) * int'(y);
        pv = p;
        return pv[2*W-1:0];
    endfunction

    function automatic logic ref_negative(input logic signed [W-1:0] x,
                                          input logic signed [W-1:0] y);
        return (int'(x) * int'(y)) < 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives start for one edge (E0); afterwards scrambles a/b to prove they are ignored.
    task automatic start_op(input logic [W-1:0] xa, input logic [W-1:0] xb);
        a = xa;
        b = xb;
        start = 1'b1;
        tick();
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
    endtask

    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 30) begin
            tick();
            lat++;
            if (busy) bcnt++;
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] xa, input logic [W-1:0] xb);
        int lat, bcnt;
        logic [2*W-1:0] exp_p;
        logic           exp_n;
        exp_p = ref_product(xa, xb);
        exp_n = ref_negative(xa, xb);
        start_op(xa, xb);
        check({tag, " busy_after_start"}, 32'(busy), 32'd1);
        wait_done(lat, bcnt);
        check({tag, " latency"}, 32'(lat), 32'(W + 1));
        check({tag, " busy_cycles"}, 32'(bcnt), 32'(W + 1));
        check({tag, " product"}, 32'(product), 32'(exp_p));
        check({tag, " negative"}, 32'(negative), 32'(exp_n));
        $display("op %s: a=%0d b=%0d product=%h negative=%0b latency=%0d",
                 tag, $signed(xa), $signed(xb), product, negative, lat);
        tick();
        check({tag, " done_one_cycle"}, 32'(done), 32'd0);
        check({tag, " product_hold"}, 32'(product), 32'(exp_p));
    endtask

    initial begin
        int lat, bcnt, ndone;
        logic [W-1:0] ra, rb;

        // Reset, then idle with no start.
        repeat (3) tick();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_outputs", {15'd0, product, negative, busy, done}, 32'd0);
        end

        // Sign handling.
        run_op("5x-3", 8'sd5, -8'sd3);
        check("5x-3 literal", 32'(product), 32'h0000_FFF1);
        run_op("-7x-6", -8'sd7, -8'sd6);
        check("-7x-6 literal", 32'(product), 32'h0000_002A);

        // Extremes.
        run_op("-128x-128", 8'h80, 8'h80);
        check("-128x-128 literal", 32'(product), 32'h0000_4000);
        run_op("-128x127", 8'h80, 8'h7F);
        check("-128x127 literal", 32'(product), 32'h0000_C080);
        run_op("127x127", 8'h7F, 8'h7F);
        check("127x127 literal", 32'(product), 32'h0000_3F01);

        // Zero results are never negative.
        run_op("-9x0", -8'sd9, 8'sd0);
        run_op("0x-1", 8'sd0, -8'sd1);

        // Start while busy is ignored.
        start_op(8'd3, 8'd4);
        repeat (3) tick();
        a = 8'd9;
        b = 8'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        a = 8'd77;
        b = 8'd55;
        wait_done(lat, bcnt);
        check("busy_start latency", 32'(lat), 32'd5);
        check("busy_start product", 32'(product), 32'd12);
        check("busy_start negative", 32'(negative), 32'd0);
        $display("op busy_start: a=3 b=4 product=%h latency_from_E4=%0d", product, lat);

        // Back-to-back: start in the done cycle.
        start_op(-8'sd2, 8'sd2);
        check("b2b busy", 32'(busy), 32'd1);
        check("b2b product_hold", 32'(product), 32'd12);
        wait_done(lat, bcnt);
        check("b2b latency", 32'(lat), 32'(W + 1));
        check("b2b busy_cycles", 32'(bcnt), 32'(W + 1));
        check("b2b product", 32'(product), 32'h0000_FFFC);
        check("b2b negative", 32'(negative), 32'd1);
        $display("op b2b: a=-2 b=2 product=%h negative=%0b latency=%0d", product, negative, lat);
        tick();

        // Random operands.
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            run_op("rand", ra, rb);
        end

        // Reset mid-run clears everything at once and no done follows.
        start_op(8'd5, 8'd7);
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        check("midrun_reset_outputs", {15'd0, product, negative, busy, done}, 32'd0);
        tick();
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done) ndone++;
        end
        check("midrun_reset_no_done", 32'(ndone), 32'd0);
        check("midrun_reset_idle", {15'd0, product, negative, busy, done}, 32'd0);
        $display("op midrun_reset: product=%h busy=%0b done_pulses=%0d", product, busy, ndone);

        // Recovers normally after reset.
        run_op("post_reset", -8'sd11, 8'sd13);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
